dram_frame_reader: RTL and testbench
====================================

// Module: dram_frame_reader
// PURPOSE
//  Upstream of the UDP frame sender: on a kick, reads read_num 32-bit words of the selected frame buffer from DRAM
//  via an AXI4 read master. Streams them out as buf_dout/buf_we into the sender's dual-clock FIFO (write side).
//  Splits requests into INCR bursts of at most MAX_BURST beats that never cross a 4 KiB boundary.
// PARAMETERS
//  ADDR_WIDTH   32            AXI address width
//  MAX_BURST    64            max beats per AR burst (1..256)
//  FRAME0_BASE  32'h0000_0000 byte base of frame buffer 0
//  FRAME1_BASE  32'h0080_0000 byte base of frame buffer 1
// PORTS
//  clk            in   1   single clock (AXI and buf_* side)
//  rst_n          in   1   asynchronous, active-low reset
//  kick           in   1   1-cycle start pulse
//  read_num       in   32  words to read; sampled with kick
//  read_addr      in   32  byte offset in frame; sampled with kick, bits[1:0] ignored
//  frame_select   in   1   0:FRAME0_BASE 1:FRAME1_BASE; sampled with kick
//  busy           out  1   transfer in progress
//  err            out  1   sticky: RRESP!=OKAY or RLAST/beat mismatch in current transfer
//  buf_dout       out  32  read word
//  buf_we         out  1   buf_dout valid (no backpressure)
//  m_axi_araddr   out  ADDR_WIDTH; m_axi_arlen out 8; m_axi_arsize out 3 (=3'b010); m_axi_arburst out 2 (=2'b01)
//  m_axi_arvalid  out  1;  m_axi_arready in 1
//  m_axi_rdata    in   32; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1
// BEHAVIOUR
//  Reset (async assert, sync deassert inside): state IDLE; busy, err, buf_we, arvalid, rready = 0; buf_dout, araddr, arlen = 0.
//  States: IDLE -> AR -> R -> (AR | IDLE).
//  IDLE: kick && read_num!=0 -> latch addr=base+{read_addr[31:2],2'b00}, remain=read_num; busy=1, err=0 next cycle; go AR.
//   kick with read_num==0: ignored, busy stays 0. kick while busy: ignored (no queueing).
//  AR: len=min(remain, MAX_BURST, (4096-addr[11:0])>>2); arvalid=1, araddr=addr, arlen=len-1, held stable until arready.
//   On arready handshake -> R. One outstanding burst only.
//  R: rready=1. Each rvalid beat: buf_dout<=rdata, buf_we<=1 (registered, 1-cycle latency); beat counter++.
//   rresp!=2'b00 -> err=1 (data still forwarded). rlast on beat!=len, or beat==len without rlast -> err=1.
//   Burst end = rvalid&&rlast: addr+=len*4, remain-=len; remain==0 -> IDLE, busy=0 same edge as last buf_we rises; else AR.
//  err is sticky until next accepted kick. Address arithmetic wraps at 2^ADDR_WIDTH without error.
//  Reset mid-transfer: immediate return to IDLE; AXI interconnect shares rst_n, outstanding beats abandoned.
// CONFIGURATION
//  DRAM_READER_STATS_EN defined: adds outputs stat_bursts[31:0] (AR handshakes) and stat_words[31:0] (buf_we pulses),
//   free-running, wrap at 2^32, cleared only by rst_n.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package dram_reader_pkg: state enum, AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, BOUNDARY_4K=4096.
//  Sub-module dram_burst_len_calc (combinational): remain, addr[11:0], MAX_BURST -> len[8:0].
// TESTING
//  1 kick, addr 0, num 64, frame 0 -> one AR araddr=0 arlen=63; 64 buf_we matching rdata; busy falls after beat 64, err=0.
//  2 addr 0xFF0, num 64 -> AR 0xFF0 arlen=3, then AR 0x1000 arlen=59; 64 words total.
//  3 frame_select=1, addr 0x100, num 200, MAX_BURST=64 -> AR at 0x0080_0100 lens 63,63,63,7.
//  4 kick during busy, and kick with num=0 -> no extra AR, busy profile unchanged/none.
//  5 rresp=SLVERR on beat 10 / rlast early at beat 30 of 64 -> err=1, data forwarded; next kick clears err.
//  6 arready delayed 5 cycles, rvalid gaps; rst_n low mid-burst -> all outputs at reset values immediately; new kick works.

Source files
------------

// File: rtl/dram_reader_pkg.sv
// Shared types and AXI constants for the DRAM frame reader.
// Build option: DRAM_READER_STATS_EN adds burst/word statistics counters to the top.
package dram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/dram_frame_reader_if.sv
// AXI4 read-channel bundle (AR + R) between the frame reader and the DRAM interconnect.
// Handshake: a transfer happens on the rising edge where valid && ready; the source holds payload stable while valid && !ready.
interface dram_frame_reader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/dram_burst_len_calc.sv
// Next burst length: min(words remaining, MAX_BURST, words left before the next 4 KiB boundary).
module dram_burst_len_calc
    import dram_reader_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic [31:0] remain,
    input  logic [9:0]  word_off,
    output logic [8:0]  len
);
    logic [10:0] room_words;
    logic [8:0]  cap;

    always_comb begin
        // word_off is the word index inside the 4 KiB page, so room is 1..1024 words
        room_words = 11'(BOUNDARY_4K / 4) - {1'b0, word_off};
        cap        = (room_words < 11'(MAX_BURST)) ? room_words[8:0] : 9'(MAX_BURST);
        len        = (remain < {23'd0, cap}) ? remain[8:0] : cap;
    end
endmodule

// File: rtl/dram_frame_reader.sv
// Reads read_num words of a frame buffer over AXI4 INCR bursts and streams them out on buf_dout/buf_we.
// Build option: DRAM_READER_STATS_EN adds stat_bursts/stat_words outputs.
module dram_frame_reader
    import dram_reader_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MAX_BURST   = 64,
    parameter logic [ADDR_WIDTH-1:0] FRAME0_BASE = '0,
    parameter logic [ADDR_WIDTH-1:0] FRAME1_BASE = ADDR_WIDTH'(32'h0080_0000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kick,
    input  logic [31:0] read_num,
    input  logic [31:0] read_addr,
    input  logic        frame_select,
    output logic        busy,
    output logic        err,
    output logic [31:0] buf_dout,
    output logic        buf_we,
`ifdef DRAM_READER_STATS_EN
    output logic [31:0] stat_bursts,
    output logic [31:0] stat_words,
`endif
    output state_t      state_dbg,
    dram_frame_reader_if.master m_axi
);
    logic [1:0]            rst_pipe;
    logic                  rst_i_n;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] base_sel;
    logic [31:0]           remain;
    logic [8:0]            len_calc, burst_len, beat_cnt, beat_num;
    logic                  start, ar_hs, r_hs, burst_end, beat_bad;
    logic                  unused_addr_lsb;

    // Assertion is immediate; release is aligned to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_i_n = rst_pipe[1];

    assign unused_addr_lsb = &{1'b0, read_addr[1:0]};

    assign start     = (state == ST_IDLE) && kick && (read_num != 32'd0);
    assign ar_hs     = m_axi.arvalid && m_axi.arready;
    assign r_hs      = m_axi.rvalid && m_axi.rready;
    assign burst_end = r_hs && m_axi.rlast;
    assign beat_num  = beat_cnt + 9'd1;
    assign beat_bad  = (m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != (beat_num == burst_len));
    assign base_sel  = frame_select ? FRAME1_BASE : FRAME0_BASE;

    dram_burst_len_calc #(.MAX_BURST(MAX_BURST)) u_len_calc (
        .remain   (remain),
        .word_off (addr[11:2]),
        .len      (len_calc)
    );

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_AR;
            ST_AR:   if (ar_hs) state_nxt = ST_R;
            ST_R:    if (burst_end) state_nxt = (remain == 32'(burst_len)) ? ST_IDLE : ST_AR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign m_axi.arvalid = (state == ST_AR);
    assign m_axi.araddr  = addr;
    assign m_axi.arlen   = m_axi.arvalid ? 8'(len_calc - 9'd1) : 8'd0;
    assign m_axi.arsize  = AXI_SIZE_4B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.rready  = (state == ST_R);
    assign busy          = (state != ST_IDLE);
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            addr      <= '0;
            remain    <= '0;
            burst_len <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            buf_we    <= 1'b0;
            buf_dout  <= '0;
        end else begin
            buf_we <= r_hs;
            if (r_hs) buf_dout <= m_axi.rdata;
            if (start) begin
                addr   <= base_sel + ADDR_WIDTH'({read_addr[31:2], 2'b00});
                remain <= read_num;
                err    <= 1'b0;
            end
            if (ar_hs) begin
                burst_len <= len_calc;
                beat_cnt  <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_num;
                if (beat_bad) err <= 1'b1;
            end
            // Advance by the requested length even if the slave ended the burst early
            if (burst_end) begin
                addr   <= addr + ADDR_WIDTH'({burst_len, 2'b00});
                remain <= remain - 32'(burst_len);
            end
        end
    end

`ifdef DRAM_READER_STATS_EN
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            stat_bursts <= '0;
            stat_words  <= '0;
        end else begin
            stat_bursts <= stat_bursts + 32'(ar_hs);
            stat_words  <= stat_words + 32'(buf_we);
        end
    end
`endif
endmodule

// File: tb/tb_dram_frame_reader.sv
// Randomized bench for dram_frame_reader: AXI read-slave model, burst-split reference model and scoreboards.
`timescale 1ns/1ps
module tb_dram_frame_reader;
    import dram_reader_pkg::*;

    localparam int          MAX_BURST = 64;
    localparam logic [31:0] F0_BASE   = 32'h0000_0000;
    localparam logic [31:0] F1_BASE   = 32'h0080_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kick = 1'b0;
    logic [31:0] read_num = '0;
    logic [31:0] read_addr = '0;
    logic        frame_select = 1'b0;
    logic        busy, err, buf_we;
    logic [31:0] buf_dout;
    state_t      state_dbg;
`ifdef DRAM_READER_STATS_EN
    logic [31:0] stat_bursts, stat_words;
`endif

    dram_frame_reader_if #(.ADDR_WIDTH(32)) axi_bus ();

    dram_frame_reader #(.ADDR_WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kick         (kick),
        .read_num     (read_num),
        .read_addr    (read_addr),
        .frame_select (frame_select),
        .busy         (busy),
        .err          (err),
        .buf_dout     (buf_dout),
        .buf_we       (buf_we),
`ifdef DRAM_READER_STATS_EN
        .stat_bursts  (stat_bursts),
        .stat_words   (stat_words),
`endif
        .state_dbg    (state_dbg),
        .m_axi        (axi_bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ar_addr_q[$];
    logic [7:0]  exp_ar_len_q[$];
    int          words_seen = 0;
    int          exp_words = 0;
    logic        exp_err = 1'b0;

    int   ar_delay = 0;
    int   gap_pct = 0;
    int   err_beat = -1;
    int   early_last = 0;
    int   xfer_beat = 0;
    logic first_burst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI read slave: random data, optional arready delay, rvalid gaps, SLVERR and early rlast injection
    initial begin
        logic in_burst, ar_hs, r_hs, last_s;
        int   beat, blen, blen_s, ar_wait;
        in_burst = 1'b0; beat = 0; blen = 0; ar_wait = 0;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rlast   = 1'b0;
        forever begin
            @(posedge clk);
            ar_hs  = axi_bus.arvalid && axi_bus.arready;
            r_hs   = axi_bus.rvalid && axi_bus.rready;
            last_s = axi_bus.rlast;
            blen_s = int'(axi_bus.arlen) + 1;
            #1;
            if (!rst_n) begin
                in_burst = 1'b0; beat = 0; ar_wait = 0;
                axi_bus.arready = 1'b0;
                axi_bus.rvalid  = 1'b0;
                axi_bus.rlast   = 1'b0;
            end else begin
                if (ar_hs) begin
                    in_burst = 1'b1; beat = 0; blen = blen_s; ar_wait = 0;
                end
                if (r_hs) begin
                    beat++;
                    xfer_beat++;
                    if (last_s) begin
                        in_burst    = 1'b0;
                        first_burst = 1'b0;
                    end
                end
                if (!in_burst && axi_bus.arvalid) begin
                    if (ar_wait >= ar_delay) axi_bus.arready = 1'b1;
                    else begin
                        axi_bus.arready = 1'b0;
                        ar_wait++;
                    end
                end else begin
                    axi_bus.arready = 1'b0;
                end
                if (!in_burst) begin
                    axi_bus.rvalid = 1'b0;
                    axi_bus.rlast  = 1'b0;
                end else if (r_hs || !axi_bus.rvalid) begin
                    if ($urandom_range(0, 99) < gap_pct) begin
                        axi_bus.rvalid = 1'b0;
                    end else begin
                        axi_bus.rdata  = $urandom;
                        axi_bus.rresp  = (xfer_beat == err_beat) ? 2'b10 : 2'b00;
                        axi_bus.rlast  = (beat == blen - 1) ||
                                         (first_burst && early_last != 0 && beat == early_last - 1);
                        axi_bus.rvalid = 1'b1;
                        exp_q.push_back(axi_bus.rdata);
                    end
                end
            end
        end
    end

    // Data monitor: every buf_we word must be the next word the slave delivered
    always @(negedge clk) begin
        if (rst_n && buf_we) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", buf_dout);
            end else begin
                check("buf_dout", buf_dout, exp_q.pop_front());
            end
        end
    end

    // AR monitor: arready is held across the edge, so a negedge sample with both high is one handshake
    always @(negedge clk) begin
        if (rst_n && axi_bus.arvalid && axi_bus.arready) begin
            if (exp_ar_addr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ar: got addr %h len %0d expected none", axi_bus.araddr, axi_bus.arlen);
            end else begin
                check("araddr", axi_bus.araddr, exp_ar_addr_q.pop_front());
                check("arlen", {24'd0, axi_bus.arlen}, {24'd0, exp_ar_len_q.pop_front()});
                check("arsize_burst", {27'd0, axi_bus.arsize, axi_bus.arburst}, {27'd0, 3'b010, 2'b01});
            end
        end
    end

    // Reference burst split: walk the transfer word range, cutting at MAX_BURST and 4 KiB pages
    task automatic model_bursts(input logic [31:0] start_addr, input int num, output int first_len);
        logic [31:0] a;
        int r, l, room;
        a = start_addr;
        r = num;
        first_len = 0;
        while (r > 0) begin
            room = (4096 - int'(a[11:0])) / 4;
            l = r;
            if (l > MAX_BURST) l = MAX_BURST;
            if (l > room) l = room;
            if (first_len == 0) first_len = l;
            exp_ar_addr_q.push_back(a);
            exp_ar_len_q.push_back(8'(l - 1));
            a = a + 32'(l * 4);
            r = r - l;
        end
    endtask

    task automatic start_xfer(input logic fsel, input logic [31:0] off, input int num,
                              input int ard, input int gap, input int eb, input int el);
        int fl;
        logic [31:0] base;
        ar_delay = ard; gap_pct = gap; err_beat = eb; early_last = el;
        xfer_beat = 0; first_burst = 1'b1; words_seen = 0;
        base = fsel ? F1_BASE : F0_BASE;
        model_bursts(base + {off[31:2], 2'b00}, num, fl);
        exp_words = (el != 0) ? num - fl + el : num;
        exp_err = (el != 0) || (eb >= 0 && eb < exp_words);
        @(negedge clk);
        kick = 1'b1; frame_select = fsel; read_addr = off; read_num = num;
        @(negedge clk);
        kick = 1'b0; read_addr = $urandom; read_num = $urandom; frame_select = ~fsel;
        check("busy_after_kick", {31'd0, busy}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
    endtask

    task automatic finish_xfer();
        int cyc;
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xfer_timeout: busy still %0d after %0d cycles, required 0", busy, cyc);
        end else begin
            check("last_we_at_busy_fall", {31'd0, buf_we}, 32'd1);
        end
        @(negedge clk);
        check("err_end", {31'd0, err}, {31'd0, exp_err});
        check("word_count", 32'(words_seen), 32'(exp_words));
        check("data_left", 32'(exp_q.size()), 32'd0);
        check("ar_left", 32'(exp_ar_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_buf_we"}, {31'd0, buf_we}, 32'd0);
        check({tag, "_buf_dout"}, buf_dout, 32'd0);
        check({tag, "_arvalid"}, {31'd0, axi_bus.arvalid}, 32'd0);
        check({tag, "_rready"}, {31'd0, axi_bus.rready}, 32'd0);
        check({tag, "_araddr"}, axi_bus.araddr, 32'd0);
        check({tag, "_arlen"}, {24'd0, axi_bus.arlen}, 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        #800000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, bench incomplete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int cyc, busy_seen;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single aligned burst, frame 0
        start_xfer(1'b0, 32'h0, 64, 0, 0, -1, 0);
        finish_xfer();
        // 4 KiB split
        start_xfer(1'b0, 32'hFF0, 64, 0, 20, -1, 0);
        finish_xfer();
        // Frame 1, multi-burst with a short tail
        start_xfer(1'b1, 32'h100, 200, 0, 0, -1, 0);
        finish_xfer();

        // Kick while busy is ignored
        start_xfer(1'b0, 32'h2000, 64, 1, 10, -1, 0);
        repeat (5) @(negedge clk);
        kick = 1'b1; read_num = 32'd5; read_addr = 32'h3000;
        @(negedge clk);
        kick = 1'b0;
        finish_xfer();
        // Kick with zero words is ignored
        kick = 1'b1; read_num = 32'd0; read_addr = 32'h40;
        @(negedge clk);
        kick = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            if (busy) busy_seen = 1;
            @(negedge clk);
        end
        check("busy_num0", 32'(busy_seen), 32'd0);

        // SLVERR on beat 10, then early rlast, then a clean transfer clears err
        start_xfer(1'b0, 32'h0, 64, 0, 0, 10, 0);
        finish_xfer();
        start_xfer(1'b0, 32'h0, 100, 0, 0, -1, 30);
        finish_xfer();
        start_xfer(1'b1, 32'h80, 40, 0, 0, -1, 0);
        finish_xfer();

        // Slow arready, rvalid gaps, reset in the middle of a transfer
        start_xfer(1'b1, 32'h40, 200, 5, 40, 5, 0);
        cyc = 0;
        while (words_seen < 20 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_mid_burst", 32'(words_seen >= 20), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_ar_addr_q.delete();
        exp_ar_len_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        start_xfer(1'b0, 32'h1F00, 90, 5, 30, -1, 0);
        finish_xfer();

        // Random transfers
        for (int i = 0; i < 6; i++) begin
            start_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 32'h3FFF),
                       $urandom_range(1, 300), $urandom_range(0, 3), $urandom_range(0, 30), -1, 0);
            finish_xfer();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
